// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, move-to selects and FSM state type shared by the multiply/divide unit
package mdu_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MADD  = 4'd4;
    localparam logic [3:0] OP_MADDU = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd6;
    localparam logic [3:0] OP_MSUBU = 4'd7;
    localparam logic [3:0] OP_NONE  = 4'd8;

    localparam logic [1:0] MT_LO   = 2'b00;
    localparam logic [1:0] MT_HI   = 2'b01;
    localparam logic [1:0] MT_NONE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply, multiply-accumulate and divide producing the next {hi,lo}
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic [2*WIDTH-1:0] i_hilo,
    output logic [2*WIDTH-1:0] o_hilo
);

    logic               w_mul_signed;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_dvs;
    logic [WIDTH-1:0]   w_uq;
    logic [WIDTH-1:0]   w_ur;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;

    // Signed multiply-class ops have op[0] clear; a sign-extended 2W x 2W product truncated to 2W is exact
    assign w_mul_signed = ~i_op[0];
    assign w_ext_a      = {{WIDTH{w_mul_signed & i_a[WIDTH-1]}}, i_a};
    assign w_ext_b      = {{WIDTH{w_mul_signed & i_b[WIDTH-1]}}, i_b};
    assign w_prod       = w_ext_a * w_ext_b;

    // Divide on magnitudes, then restore signs; min / -1 wraps back to min with remainder 0 naturally
    assign w_a_neg  = (i_op == OP_DIV) & i_a[WIDTH-1];
    assign w_b_neg  = (i_op == OP_DIV) & i_b[WIDTH-1];
    assign w_b_zero = (i_b == '0);
    assign w_mag_a  = w_a_neg ? -i_a : i_a;
    assign w_mag_b  = w_b_neg ? -i_b : i_b;
    assign w_dvs    = w_b_zero ? WIDTH'(1) : w_mag_b;
    assign w_uq     = w_mag_a / w_dvs;
    assign w_ur     = w_mag_a % w_dvs;
    assign w_q      = (w_a_neg ^ w_b_neg) ? -w_uq : w_uq;
    assign w_r      = w_a_neg ? -w_ur : w_ur;

    // Select the next {hi,lo} by operation class; anything else leaves it unchanged
    always_comb begin
        o_hilo = i_hilo;
        case (i_op)
            OP_MULT, OP_MULTU: o_hilo = w_prod;
            OP_MADD, OP_MADDU: o_hilo = i_hilo + w_prod;
            OP_MSUB, OP_MSUBU: o_hilo = i_hilo - w_prod;
            OP_DIV, OP_DIVU:   o_hilo = w_b_zero ? {i_a, {WIDTH{1'b1}}} : {w_r, w_q};
            default:           ;
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with HI/LO registers, countdown latency and flush
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mthilo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [CW-1:0]      w_cnt_nxt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_idle;
    logic               w_is_mul;
    logic               w_is_div;
    logic               w_accept;
    logic               w_done;
    logic               w_mt_hi;
    logic               w_mt_lo;
    logic [2*WIDTH-1:0] w_result;

    assign w_idle   = (r_state == S_IDLE);
    assign w_is_mul = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    assign w_is_div = op inside {OP_DIV, OP_DIVU};
    assign w_accept = w_idle & start & ~flush & (w_is_mul | w_is_div);
    assign w_done   = ~w_idle & ~flush & (r_cnt == CW'(1));
    assign w_mt_hi  = w_idle & ~start & (mthilo == MT_HI);
    assign w_mt_lo  = w_idle & ~start & (mthilo == MT_LO);

    assign busy = ~w_idle;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // hi/lo cannot change while busy, so the live registers serve as the captured accumulator
    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .i_op   (r_op),
        .i_a    (r_a),
        .i_b    (r_b),
        .i_hilo ({r_hi, r_lo}),
        .o_hilo (w_result)
    );

    // State and countdown register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: launch on an accepted start, count down, return to idle at 1 or on flush
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_idle) begin
            if (w_accept) begin
                w_state_nxt = w_is_div ? S_DIV : S_MUL;
                w_cnt_nxt   = w_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
            end
        end else if (flush || r_cnt == CW'(1)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            w_cnt_nxt   = r_cnt - CW'(1);
        end
    end

    // Capture the operation and operands on an accepted start
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op <= OP_NONE;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
        end
    end

    // HI/LO: load the result on completion, otherwise accept move-to writes while idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            {r_hi, r_lo} <= w_result;
        end else begin
            if (w_mt_hi) r_hi <= wdata;
            if (w_mt_lo) r_lo <= wdata;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: vector table, random model checks and hand-written abort sequences for mul_div_unit
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        start   = 1'b0;
    logic        flush   = 1'b0;
    logic [3:0]  op      = OP_NONE;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;
    logic [31:0] wdata   = '0;
    logic [1:0]  mthilo  = MT_NONE;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] cur_hi = '0;
    logic [31:0] cur_lo = '0;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;
    res_t sb[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthilo  (mthilo),
        .wdata   (wdata),
        .flush   (flush),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint p;
        int     q;
        int     r;
        if (o == OP_MULT) begin
            p = longint'($signed(x)) * longint'($signed(y));
            return p;
        end
        if (o == OP_MULTU) return {32'd0, x} * {32'd0, y};
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        if (o == OP_DIVU) return {x % y, x / y};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'd0, x};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
    endfunction

    task automatic run_op(input string nm, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int lat, input logic [31:0] eh, input logic [31:0] el);
        int   n;
        res_t r;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb.push_back('{eh, el});
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
        chk({nm, "_busy_rise"}, 64'(busy), 64'd1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_latency"}, 64'(n), 64'(lat));
        r = sb.pop_front();
        chk({nm, "_hi"}, 64'(hi), 64'(r.hi));
        chk({nm, "_lo"}, 64'(lo), 64'(r.lo));
        cur_hi = r.hi;
        cur_lo = r.lo;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   n;
        res_t r;
        vecs[0] = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[2] = '{OP_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 10};
        vecs[3] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
        vecs[4] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[5] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
        vecs[6] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        vecs[7] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        10};
        vecs[8] = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 10};
        vecs[9] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        5};

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        @(negedge clk);
        mthilo = MT_HI;
        wdata  = 32'd1;
        @(negedge clk);
        mthilo = MT_LO;
        wdata  = 32'hFFFFFFFF;
        @(negedge clk);
        mthilo = MT_NONE;
        chk("mthi", 64'(hi), 64'd1);
        chk("mtlo", 64'(lo), 64'hFFFFFFFF);
        run_op("maddu", OP_MADDU, 32'd1, 32'd1, 5, 32'd2, 32'd0);
        run_op("msub", OP_MSUB, 32'd1, 32'd1, 5, 32'd1, 32'hFFFFFFFF);

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hi, vecs[i].lo);

        for (int i = 0; i < 8; i++) begin
            logic [3:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            logic [63:0] e;
            o = 4'($urandom_range(0, 3));
            x = $urandom;
            y = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            e = model(o, x, y);
            run_op($sformatf("rnd%0d", i), o, x, y, (o == OP_DIV || o == OP_DIVU) ? 10 : 5, e[63:32], e[31:0]);
        end

        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd6;
        b     = 32'd7;
        sb.push_back('{32'd0, 32'd42});
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
        @(negedge clk);
        start  = 1'b1;
        op     = OP_DIVU;
        a      = 32'd1;
        b      = 32'd1;
        mthilo = MT_HI;
        wdata  = 32'hDEAD;
        @(negedge clk);
        start  = 1'b0;
        op     = OP_NONE;
        mthilo = MT_NONE;
        n = 2;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("busy_ign_latency", 64'(n), 64'd5);
        r = sb.pop_front();
        chk("busy_ign_hi", 64'(hi), 64'(r.hi));
        chk("busy_ign_lo", 64'(lo), 64'(r.lo));
        cur_hi = r.hi;
        cur_lo = r.lo;
        @(negedge clk);
        chk("busy_ign_no_restart", 64'(busy), 64'd0);

        @(negedge clk);
        start  = 1'b1;
        op     = OP_NONE;
        mthilo = MT_HI;
        wdata  = 32'h1234;
        @(negedge clk);
        start  = 1'b0;
        mthilo = MT_NONE;
        chk("none_busy", 64'(busy), 64'd0);
        chk("none_mt_blocked", 64'(hi), 64'(cur_hi));
        @(negedge clk);
        start = 1'b1;
        op    = 4'd13;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
        chk("op13_busy", 64'(busy), 64'd0);

        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = OP_MULT;
        a     = 32'd2;
        b     = 32'd2;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        op    = OP_NONE;
        chk("flush_start_busy", 64'(busy), 64'd0);
        repeat (6) @(negedge clk);
        chk("flush_start_hilo", {32'(hi), 32'(lo)}, {cur_hi, cur_lo});

        @(negedge clk);
        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd100;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush4_busy", 64'(busy), 64'd0);
        chk("flush4_hilo", {32'(hi), 32'(lo)}, {cur_hi, cur_lo});
        run_op("after_flush", OP_MULT, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);

        @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd5;
        b     = 32'd5;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
        repeat (4) @(negedge clk);
        chk("flushdone_busy_last", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flushdone_busy", 64'(busy), 64'd0);
        chk("flushdone_hilo", {32'(hi), 32'(lo)}, {cur_hi, cur_lo});

        @(negedge clk);
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd7;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        cur_hi = '0;
        cur_lo = '0;
        run_op("post_reset", OP_MULTU, 32'd3, 32'd4, 5, 32'd0, 32'd12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
